instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 5, is the program-counter and instruction-address width (32-entry program store).
REQ-002 Parameter CNT_W, default 16, is the width of the issued-instruction counter.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req_o  output  1  instruction read request to program memory.
REQ-006 imem_addr_o  output  ADDR_W  read address, equals PC.
REQ-007 imem_rdata_i  input  32  instruction word, valid with imem_valid_i.
REQ-008 imem_valid_i  input  1  read data valid; arbitrary latency of 1 cycle or more after request.
REQ-009 ir_o  output  32  instruction to execute stage (oper [31:27], rdst [26:22], rsrc1 [21:17], imm_mode [16], rsrc2 [15:11] / imm [15:0]).
REQ-010 ir_valid_o  output  1  ir_o holds an instruction for execute.
REQ-011 ir_ready_i  input  1  execute stage accepts ir_o this cycle.
REQ-012 sign_i, zero_i, overflow_i, carry_i  input  1 each  condition flags from execute stage.
REQ-013 halted_o  output  1  core stopped on a halt instruction.
REQ-014 issued_cnt_o  output  CNT_W  count of instructions handed to execute (present only with PERF_CNT_EN).

Function
REQ-015 The FSM SHALL have the states FETCH, WAIT, DECODE, ISSUE and HALT.
REQ-016 FETCH: assert imem_req_o for exactly 1 cycle with imem_addr_o = PC, then go to WAIT.
REQ-017 WAIT: hold imem_addr_o; on imem_valid_i, latch imem_rdata_i into IR and go to DECODE; imem_valid_i outside WAIT SHALL be ignored.
REQ-018 DECODE (1 cycle): opcodes 0-11 (ALU, mov, movsgpr) go to ISSUE; control opcodes are consumed locally and never issued to execute.
REQ-019 Control opcodes: 12 jump, 13 jcarry, 14 jnocarry, 15 jsign, 16 jzero, 17 jover, 18 halt; opcodes 19-31 are treated as NOP (PC+1, back to FETCH, not issued).
REQ-020 Jump target = IR[ADDR_W-1:0]; taken: PC <= target; not taken: PC <= PC+1; then FETCH.
REQ-021 Conditions: jump always; jcarry carry_i=1; jnocarry carry_i=0; jsign sign_i=1; jzero zero_i=1; jover overflow_i=1; flags sampled in DECODE.
REQ-022 ISSUE: ir_valid_o=1 and ir_o stable until the cycle with ir_ready_i=1; on that edge PC <= PC+1, ir_valid_o falls and state goes to FETCH.
REQ-023 halt: go to HALT, halted_o=1, no further requests; leave HALT only by reset.
REQ-024 PC increment and branch targets SHALL wrap modulo 2^ADDR_W (PC 31 + 1 = 0 at default).
REQ-025 Minimum cycles per ALU instruction = 4 (FETCH, WAIT with 1-cycle memory, DECODE, ISSUE with ready high).

Reset
REQ-026 While rst_n=0: PC=0, state=FETCH, IR=0, ir_o=0, ir_valid_o=0, imem_req_o=0, halted_o=0, issued_cnt_o=0.
REQ-027 Reset asserted in any state SHALL abort the operation immediately; a read returning after reset release is ignored until the new FETCH.
REQ-028 The first imem_req_o (address 0) SHALL occur in the first clock cycle after rst_n rises.

Configuration
REQ-029 Macro PERF_CNT_EN defined: issued_cnt_o exists and increments on each ir_valid_o and ir_ready_i handshake, saturating at 2^CNT_W-1.
REQ-030 Macro PERF_CNT_EN undefined: the issued_cnt_o port and counter logic are absent; all other behaviour is identical.

Verification
REQ-031 Program {add, sub, mov} at 0-2, memory latency 1, ir_ready_i=1 -> ir_o presented in order at PC 0, 1, 2 at 4-cycle spacing; issued_cnt_o=3.
REQ-032 ir_ready_i held low 5 cycles in ISSUE -> ir_o and ir_valid_o stable for 5 cycles; PC advances only after ready.
REQ-033 jzero to 7 with zero_i=1 -> next imem_addr_o=7; same with zero_i=0 -> next imem_addr_o=PC+1; ir_valid_o never asserted for the jump.
REQ-034 ALU instruction at address 31 -> next fetch address 0.
REQ-035 halt at address 4 -> halted_o=1, imem_req_o stays 0 for 20 cycles; rst_n pulse -> fetch restarts at address 0.
REQ-036 rst_n asserted in WAIT with imem_valid_i arriving after release -> data ignored, state is FETCH, PC=0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: multi-cycle instruction fetch / decode front end.
// Fetches one 32-bit word per instruction from a variable-latency program store, resolves
// control instructions (jumps, halt, NOPs) locally and hands ALU/move instructions to the
// execute stage over a valid/ready handshake.
// Optional feature: define PERF_CNT_EN to add the saturating issued-instruction counter
// output issued_cnt_o. Without it the port and the counter do not exist.
module instr_fetch #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    input  logic              imem_valid_i,
    output logic [31:0]       ir_o,
    output logic              ir_valid_o,
    input  logic              ir_ready_i,
    input  logic              sign_i,
    input  logic              zero_i,
    input  logic              overflow_i,
    input  logic              carry_i,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0]  issued_cnt_o,
`endif
    output logic              halted_o
);

    typedef enum logic [2:0] {
        StFetch,
        StWait,
        StDecode,
        StIssue,
        StHalt
    } state_e;

    // Control opcodes; everything below OpJump goes to execute, above OpHalt is a NOP.
    localparam logic [4:0] OpJump     = 5'd12;
    localparam logic [4:0] OpJcarry   = 5'd13;
    localparam logic [4:0] OpJnocarry = 5'd14;
    localparam logic [4:0] OpJsign    = 5'd15;
    localparam logic [4:0] OpJzero    = 5'd16;
    localparam logic [4:0] OpJover    = 5'd17;
    localparam logic [4:0] OpHalt     = 5'd18;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [4:0]        opcode;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jump_target;
    logic              jump_taken;

    assign opcode      = ir_q[31:27];
    // Natural ADDR_W-bit overflow gives the required wrap from the last address to 0.
    assign pc_inc      = pc_q + ADDR_W'(1);
    assign jump_target = ir_q[ADDR_W-1:0];

    // Branch condition, evaluated on the flags present during DECODE.
    always_comb begin
        jump_taken = 1'b0;
        case (opcode)
            OpJump:     jump_taken = 1'b1;
            OpJcarry:   jump_taken = carry_i;
            OpJnocarry: jump_taken = ~carry_i;
            OpJsign:    jump_taken = sign_i;
            OpJzero:    jump_taken = zero_i;
            OpJover:    jump_taken = overflow_i;
            default:    jump_taken = 1'b0;
        endcase
    end

    // Next-state, next-PC and instruction-register update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            StFetch: begin
                state_d = StWait;
            end
            StWait: begin
                // Read data is only meaningful here; pulses in other states are dropped.
                if (imem_valid_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opcode < OpJump) begin
                    state_d = StIssue;
                end else if (opcode == OpHalt) begin
                    state_d = StHalt;
                end else begin
                    // Jumps and NOPs never reach execute.
                    pc_d    = jump_taken ? jump_target : pc_inc;
                    state_d = StFetch;
                end
            end
            StIssue: begin
                if (ir_ready_i) begin
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // State, PC and IR registers; reset restarts fetching from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Request is gated by rst_n so it stays low during reset yet rises the moment reset lifts.
    assign imem_req_o  = rst_n && (state_q == StFetch);
    assign imem_addr_o = pc_q;
    assign ir_o        = ir_q;
    assign ir_valid_o  = (state_q == StIssue);
    assign halted_o    = (state_q == StHalt);

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] issued_cnt_q;

    // Count accepted issue handshakes, sticking at the all-ones value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt_q <= '0;
        end else if (ir_valid_o && ir_ready_i && (issued_cnt_q != '1)) begin
            issued_cnt_q <= issued_cnt_q + CNT_W'(1);
        end
    end

    assign issued_cnt_o = issued_cnt_q;
`else
    // Counter width only matters when the counter is built.
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch.
// A program-level reference model walks the program store and queues the expected fetch
// addresses and issued words; a monitor pops and compares them as the DUT produces them.
module tb_instr_fetch;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_rdata_i;
    logic          imem_valid_i;
    logic [31:0]   ir_o;
    logic          ir_valid_o;
    logic          ir_ready_i;
    logic          sign_i = 1'b0;
    logic          zero_i = 1'b0;
    logic          overflow_i = 1'b0;
    logic          carry_i = 1'b0;
    logic          halted_o;
`ifdef PERF_CNT_EN
    logic [15:0]   issued_cnt_o;
`endif

    instr_fetch #(
        .ADDR_W(AW),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_rdata_i(imem_rdata_i),
        .imem_valid_i(imem_valid_i),
        .ir_o        (ir_o),
        .ir_valid_o  (ir_valid_o),
        .ir_ready_i  (ir_ready_i),
        .sign_i      (sign_i),
        .zero_i      (zero_i),
        .overflow_i  (overflow_i),
        .carry_i     (carry_i),
`ifdef PERF_CNT_EN
        .issued_cnt_o(issued_cnt_o),
`endif
        .halted_o    (halted_o)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment configuration (written by the driver only).
    logic [31:0] prog [0:31];
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_mode = 0;  // 0: always ready, 1: random, 2: five stall cycles per issue
    bit          spurious_en = 1'b0;
    int          stale_seq = 0;
    int          max_fetch = 64;
    bit          exp_halt = 1'b0;

    // Scoreboard.
    int          exp_fetch[$];
    logic [31:0] exp_issue[$];
    int          hs_cycle[$];
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: execute the program at instruction level from PC 0.
    function automatic void build_model();
        int pc;
        int op;
        bit taken;
        logic [31:0] w;
        pc = 0;
        exp_halt = 1'b0;
        exp_fetch.delete();
        exp_issue.delete();
        hs_cycle.delete();
        for (int n = 0; n < max_fetch; n++) begin
            w = prog[pc];
            op = int'(w[31:27]);
            exp_fetch.push_back(pc);
            if (op < 12) begin
                exp_issue.push_back(w);
                pc = (pc + 1) % 32;
            end else if (op == 18) begin
                exp_halt = 1'b1;
                break;
            end else if (op <= 17) begin
                case (op)
                    12:      taken = 1'b1;
                    13:      taken = carry_i;
                    14:      taken = !carry_i;
                    15:      taken = sign_i;
                    16:      taken = zero_i;
                    default: taken = overflow_i;
                endcase
                pc = taken ? int'(w[4:0]) : (pc + 1) % 32;
            end else begin
                pc = (pc + 1) % 32;
            end
        end
    endfunction

    function automatic logic [31:0] mk(input int op, input int tgt);
        logic [31:0] w;
        w = $urandom();
        w[31:27] = 5'(op);
        if (op >= 12 && op <= 17) w[4:0] = 5'(tgt);
        return w;
    endfunction

    // Program memory: variable latency, drops pending reads on reset, optional junk pulses.
    initial begin
        int   cnt;
        int   a;
        int   stale_done;
        bit   pend;
        bit   req_seen;
        int   addr_seen;
        imem_valid_i = 1'b0;
        imem_rdata_i = '0;
        pend = 1'b0;
        cnt = 0;
        a = 0;
        stale_done = 0;
        forever begin
            @(negedge clk);
            #2;
            req_seen = rst_n && imem_req_o;
            addr_seen = int'(imem_addr_o);
            if (stale_seq != stale_done) begin
                // Late answer to a read that was cut off by reset.
                stale_done = stale_seq;
                imem_valid_i = 1'b1;
                imem_rdata_i = 32'h9000_0000;
            end
            @(posedge clk);
            #1;
            imem_valid_i = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (req_seen) begin
                    pend = 1'b1;
                    cnt = $urandom_range(lat_max, lat_min);
                    a = addr_seen;
                end
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend = 1'b0;
                        imem_valid_i = 1'b1;
                        imem_rdata_i = prog[a];
                    end
                end else if (spurious_en && $urandom_range(3, 0) == 0) begin
                    imem_valid_i = 1'b1;
                    imem_rdata_i = $urandom();
                end
            end
        end
    end

    // Execute-stage ready generator.
    initial begin
        int low_cnt;
        low_cnt = 0;
        ir_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (ready_mode)
                0: ir_ready_i = 1'b1;
                1: ir_ready_i = ($urandom_range(2, 0) != 0);
                default: begin
                    if (ir_valid_o) begin
                        ir_ready_i = (low_cnt >= 5);
                        low_cnt = ir_ready_i ? 0 : low_cnt + 1;
                    end else begin
                        ir_ready_i = 1'b0;
                        low_cnt = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: compare fetch addresses and issued words against the scoreboard queues.
    initial begin
        bit          prev_stall;
        logic [31:0] prev_ir;
        int          a;
        logic [31:0] w;
        prev_stall = 1'b0;
        prev_ir = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("issue_hold_valid", 32'(ir_valid_o), 32'd1);
                check("issue_hold_ir", ir_o, prev_ir);
            end
            if (imem_req_o && exp_fetch.size() > 0) begin
                a = exp_fetch.pop_front();
                check("fetch_addr", 32'(imem_addr_o), 32'(a));
            end
            if (ir_valid_o && ir_ready_i) begin
                hs_cycle.push_back(cyc);
                if (exp_issue.size() > 0) begin
                    w = exp_issue.pop_front();
                    check("issue_word", ir_o, w);
                end
            end
            prev_stall = ir_valid_o && !ir_ready_i;
            prev_ir = ir_o;
        end
    end

    task automatic hold_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(ir_valid_o), 32'd0);
        check("rst_halted", 32'(halted_o), 32'd0);
        check("rst_ir", ir_o, 32'd0);
        check("rst_pc", 32'(imem_addr_o), 32'd0);
`ifdef PERF_CNT_EN
        check("rst_cnt", 32'(issued_cnt_o), 32'd0);
`endif
        @(negedge clk);
    endtask

    task automatic release_reset(input bit stale);
        build_model();
        if (stale) stale_seq++;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_addr", 32'(imem_addr_o), 32'd0);
    endtask

    task automatic wait_done(input string name);
        int n;
        int reqs;
        n = 0;
        while ((exp_fetch.size() != 0 || exp_issue.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(exp_fetch.size() + exp_issue.size()), 32'd0);
        if (exp_halt) begin
            n = 0;
            while (!halted_o && n < 12) begin
                @(negedge clk);
                #3;
                n++;
            end
            check({name, "_halted"}, 32'(halted_o), 32'd1);
            check({name, "_halt_no_issue"}, 32'(ir_valid_o), 32'd0);
            reqs = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                #3;
                if (imem_req_o) reqs++;
            end
            check({name, "_halt_quiet"}, 32'(reqs), 32'd0);
        end
    endtask

    function automatic bit spacing_ok(input int n, input int gap);
        if (hs_cycle.size() != n) return 1'b0;
        for (int i = 1; i < n; i++) begin
            if (hs_cycle[i] - hs_cycle[i-1] != gap) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < 32; i++) prog[i] = 32'h9000_0000;
    endtask

    task automatic random_program();
        int sel;
        for (int i = 0; i < 32; i++) begin
            sel = $urandom_range(99, 0);
            if (sel < 60)      prog[i] = mk($urandom_range(11, 0), 0);
            else if (sel < 85) prog[i] = mk($urandom_range(17, 12), $urandom_range(31, 0));
            else if (sel < 97) prog[i] = mk($urandom_range(31, 19), 0);
            else               prog[i] = mk(18, 0);
        end
    endtask

    // Driver.
    initial begin
        int sz;
        int n;
        hold_reset();

        // Three ALU/move instructions back to back, single-cycle memory, always ready.
        fill_halt();
        prog[0] = mk(0, 0);
        prog[1] = mk(1, 0);
        prog[2] = mk(9, 0);
        lat_min = 1; lat_max = 1; ready_mode = 0; spurious_en = 1'b0; max_fetch = 64;
        release_reset(1'b0);
        wait_done("seq3");
        check("seq3_spacing4", 32'(spacing_ok(3, 4)), 32'd1);
`ifdef PERF_CNT_EN
        check("seq3_cnt", 32'(issued_cnt_o), 32'd3);
`endif

        // Same program with five stall cycles per issue.
        hold_reset();
        ready_mode = 2;
        release_reset(1'b0);
        wait_done("stall");
        check("stall_spacing9", 32'(spacing_ok(3, 9)), 32'd1);

        // jzero to 7, taken and not taken.
        for (int z = 0; z < 2; z++) begin
            hold_reset();
            fill_halt();
            prog[0] = mk(16, 7);
            prog[1] = mk(3, 0);
            prog[7] = mk(4, 0);
            zero_i = (z == 0);
            carry_i = (z == 0) ? 1'b0 : 1'b1;
            sign_i = carry_i;
            overflow_i = carry_i;
            ready_mode = 0;
            release_reset(1'b0);
            wait_done(z == 0 ? "jzero_taken" : "jzero_not");
            check(z == 0 ? "jzero_taken_issues" : "jzero_not_issues",
                  32'(hs_cycle.size()), 32'd1);
        end

        // PC wrap from 31 to 0.
        hold_reset();
        fill_halt();
        prog[0] = mk(12, 31);
        prog[31] = mk(5, 0);
        max_fetch = 7;
        release_reset(1'b0);
        wait_done("wrap");

        // Halt at address 4; reset afterwards restarts from 0.
        hold_reset();
        fill_halt();
        for (int i = 0; i < 4; i++) prog[i] = mk(i + 2, 0);
        max_fetch = 64;
        release_reset(1'b0);
        wait_done("halt4");

        // Reset while waiting on a slow read; its late answer must be ignored.
        hold_reset();
        lat_min = 3; lat_max = 3;
        release_reset(1'b0);
        sz = exp_fetch.size();
        n = 0;
        while (exp_fetch.size() == sz && n < 50) begin
            @(negedge clk);
            #4;
            n++;
        end
        hold_reset();
        lat_min = 1; lat_max = 1;
        release_reset(1'b1);
        wait_done("rst_in_wait");

        // Randomized programs, flags, latency, backpressure and junk read pulses.
        for (int r = 0; r < 10; r++) begin
            hold_reset();
            random_program();
            sign_i = 1'($urandom_range(1, 0));
            zero_i = 1'($urandom_range(1, 0));
            overflow_i = 1'($urandom_range(1, 0));
            carry_i = 1'($urandom_range(1, 0));
            lat_min = 1;
            lat_max = $urandom_range(3, 1);
            ready_mode = 1;
            spurious_en = 1'b1;
            max_fetch = 40;
            release_reset($urandom_range(2, 0) == 0);
            wait_done("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached with checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
